// File: rtl/sumadorq_acc.sv
// -----------------------------------------------------------------------------
// sumadorq_acc
// Registered add / subtract / accumulate unit with valid/ready handshakes.
// Parametrised successor of the 5-bit SUMADORQ22 adder.
//
// Parameters
//   W      operand width of a and b
//   ACC_W  result / accumulator width (must be >= W+1)
//   SAT    1 = accumulator saturates at all ones, 0 = accumulator wraps
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   operand/mode beat valid
//   in_ready   block can accept a beat this cycle
//   mode       00 add, 01 sub, 10 accumulate, 11 load accumulator
//   a, b       unsigned operands (b ignored in modes 10/11)
//   out_valid  result register holds an unconsumed result
//   out_ready  downstream accepts result
//   out_data   result
//   out_flag   carry (add/acc) or borrow (sub); 0 for load
//   op_count   accepted input beats, wraps 255 -> 0
// -----------------------------------------------------------------------------
module sumadorq_acc #(
  parameter int W     = 5,
  parameter int ACC_W = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_flag,
  output logic [7:0]       op_count
);

  generate
    if (ACC_W < W + 1) begin : g_width_check
      $error("sumadorq_acc: ACC_W must be at least W+1");
    end
  endgenerate

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_ACC  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] out_data_reg;
  logic             out_flag_reg;
  logic             out_valid_reg;
  logic [7:0]       op_count_reg;

  logic             accept;
  logic             consume;

  logic [ACC_W-1:0] a_ext;
  logic [ACC_W-1:0] b_ext;
  logic [ACC_W:0]   add_sum;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_next;
  logic [ACC_W-1:0] data_next;
  logic             flag_next;

  // Single result register: a beat can enter whenever the slot is empty or
  // is being drained in the same cycle.
  assign in_ready = !out_valid_reg || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_reg && out_ready;

  assign a_ext = {{(ACC_W-W){1'b0}}, a};
  assign b_ext = {{(ACC_W-W){1'b0}}, b};

  assign add_sum = {1'b0, a_ext} + {1'b0, b_ext};
  assign acc_sum = {1'b0, acc_reg} + {1'b0, a_ext};

  always_comb begin
    acc_next  = acc_reg;
    data_next = '0;
    flag_next = 1'b0;
    case (mode)
      MODE_ADD: begin
        data_next = add_sum[ACC_W-1:0];
        // Operands are W bits, so the carry of interest leaves bit W-1.
        flag_next = add_sum[W];
      end
      MODE_SUB: begin
        data_next = a_ext - b_ext;
        flag_next = (a < b);
      end
      MODE_ACC: begin
        if (SAT && acc_sum[ACC_W]) begin
          acc_next = '1;
        end else begin
          acc_next = acc_sum[ACC_W-1:0];
        end
        data_next = acc_next;
        flag_next = acc_sum[ACC_W];
      end
      MODE_LOAD: begin
        acc_next  = a_ext;
        data_next = a_ext;
        flag_next = 1'b0;
      end
      default: begin
        acc_next  = acc_reg;
        data_next = '0;
        flag_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg       <= '0;
      out_data_reg  <= '0;
      out_flag_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      op_count_reg  <= '0;
    end else begin
      if (accept) begin
        // acc_next equals acc_reg for add/sub, so acc only moves in modes 10/11.
        acc_reg       <= acc_next;
        out_data_reg  <= data_next;
        out_flag_reg  <= flag_next;
        out_valid_reg <= 1'b1;
        op_count_reg  <= op_count_reg + 8'd1;
      end else if (consume) begin
        // Data and flag hold their last value once drained.
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_flag  = out_flag_reg;
  assign op_count  = op_count_reg;

endmodule

// File: tb/tb_sumadorq_acc.sv
module tb_sumadorq_acc;

  localparam int W     = 5;
  localparam int ACC_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [W-1:0]     a = '0;
  logic [W-1:0]     b = '0;
  logic             out_ready = 1'b0;

  logic             in_ready0, in_ready1;
  logic             out_valid0, out_valid1;
  logic [ACC_W-1:0] out_data0, out_data1;
  logic             out_flag0, out_flag1;
  logic [7:0]       op_count0, op_count1;

  always #5 clk = ~clk;

  sumadorq_acc #(.W(W), .ACC_W(ACC_W), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .mode(mode), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .out_flag(out_flag0), .op_count(op_count0)
  );

  sumadorq_acc #(.W(W), .ACC_W(ACC_W), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .mode(mode), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .out_flag(out_flag1), .op_count(op_count1)
  );

  typedef struct {
    int d0; int f0; int d1; int f1;
  } exp_t;

  exp_t q_sb[$];
  int   checks = 0;
  int   errors = 0;
  int   m_acc0 = 0;
  int   m_acc1 = 0;
  int   m_cnt  = 0;
  int   m_valid = 0;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input int av, input int bv,
                       input logic ordy);
    in_valid  = v;
    mode      = m;
    a         = W'(av);
    b         = W'(bv);
    out_ready = ordy;
  endtask

  // One clock: check at negedge, update scoreboard, advance past posedge.
  task automatic cycle();
    logic acc_b, con_b;
    exp_t e;
    int s;
    @(negedge clk);
    chk("in_ready", int'(in_ready0), int'((m_valid == 0) || out_ready));
    chk("in_ready_sat", int'(in_ready1), int'((m_valid == 0) || out_ready));
    chk("out_valid", int'(out_valid0), m_valid);
    chk("out_valid_sat", int'(out_valid1), m_valid);
    chk("op_count", int'(op_count0), m_cnt);
    acc_b = in_valid && ((m_valid == 0) || out_ready);
    con_b = (m_valid != 0) && out_ready;
    if (m_valid != 0) begin
      if (q_sb.size() == 0) begin
        chk("sb_nonempty", 0, 1);
      end else begin
        e = q_sb[0];
        chk("data", int'(out_data0), e.d0);
        chk("flag", int'(out_flag0), e.f0);
        chk("data_sat", int'(out_data1), e.d1);
        chk("flag_sat", int'(out_flag1), e.f1);
        $display("result mode-resp data=%0d flag=%0d data_sat=%0d flag_sat=%0d consumed=%0d",
                 out_data0, out_flag0, out_data1, out_flag1, con_b);
        if (con_b) void'(q_sb.pop_front());
      end
    end
    if (acc_b) begin
      case (mode)
        2'b00: begin
          s = int'(a) + int'(b);
          e.d0 = s; e.f0 = (s >= 32) ? 1 : 0;
          e.d1 = e.d0; e.f1 = e.f0;
        end
        2'b01: begin
          e.d0 = (int'(a) - int'(b)) & 255; e.f0 = (a < b) ? 1 : 0;
          e.d1 = e.d0; e.f1 = e.f0;
        end
        2'b10: begin
          s = m_acc0 + int'(a);
          e.f0 = (s > 255) ? 1 : 0; m_acc0 = s & 255; e.d0 = m_acc0;
          s = m_acc1 + int'(a);
          e.f1 = (s > 255) ? 1 : 0; m_acc1 = (s > 255) ? 255 : s; e.d1 = m_acc1;
        end
        default: begin
          m_acc0 = int'(a); m_acc1 = int'(a);
          e.d0 = int'(a); e.f0 = 0; e.d1 = int'(a); e.f1 = 0;
        end
      endcase
      q_sb.push_back(e);
      m_cnt = (m_cnt + 1) & 255;
      $display("accept mode=%0d a=%0d b=%0d exp_data=%0d exp_sat=%0d", mode, a, b, e.d0, e.d1);
    end
    if (acc_b) m_valid = 1;
    else if (con_b) m_valid = 0;
    @(posedge clk);
    #1;
  endtask

  // Asserts reset, checks the asynchronous effect, releases on a negedge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", int'(out_valid0), 0);
    chk("rst_out_valid_sat", int'(out_valid1), 0);
    chk("rst_out_data", int'(out_data0), 0);
    chk("rst_out_flag", int'(out_flag0), 0);
    chk("rst_op_count", int'(op_count0), 0);
    chk("rst_in_ready", int'(in_ready0), 1);
    $display("reset applied out_valid=%0d op_count=%0d", out_valid0, op_count0);
    q_sb.delete();
    m_acc0 = 0; m_acc1 = 0; m_cnt = 0; m_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // Add with carry out of bit W
    drive(1, 2'b00, 31, 31, 1); cycle();
    drive(0, 2'b00, 0, 0, 1);   cycle();
    drive(1, 2'b00, 7, 9, 1);   cycle();

    // Subtract with and without borrow
    drive(1, 2'b01, 3, 5, 1);   cycle();
    drive(1, 2'b01, 5, 3, 1);   cycle();
    drive(0, 2'b00, 0, 0, 1);   cycle();

    // Accumulate up to 250 then overflow: wraps to 4 vs saturates at 255
    drive(1, 2'b11, 31, 0, 1);  cycle();
    for (int i = 0; i < 7; i++) begin
      drive(1, 2'b10, 31, 0, 1); cycle();
    end
    drive(1, 2'b10, 2, 0, 1);   cycle();
    drive(1, 2'b10, 10, 0, 1);  cycle();
    drive(1, 2'b01, 9, 1, 1);   cycle();  // sub must leave acc untouched
    drive(1, 2'b10, 1, 0, 1);   cycle();
    drive(0, 2'b00, 0, 0, 1);   cycle();

    // Backpressure: second beat stalls until out_ready rises
    drive(1, 2'b00, 1, 2, 0);   cycle();
    drive(1, 2'b00, 4, 5, 0);   cycle();
    cycle();
    drive(1, 2'b00, 4, 5, 1);   cycle();
    drive(0, 2'b00, 0, 0, 1);   cycle();
    cycle();

    // Reset while a result is pending and acc=17
    drive(1, 2'b11, 17, 0, 0);  cycle();
    drive(0, 2'b00, 0, 0, 0);   cycle();
    do_reset();
    drive(1, 2'b10, 1, 0, 1);   cycle();
    drive(0, 2'b00, 0, 0, 1);   cycle();

    // op_count wrap after 256 accepted beats
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(1, 2'(i % 4), i % 32, (i * 7) % 32, 1); cycle();
    end
    drive(0, 2'b00, 0, 0, 1);   cycle();
    chk("op_count_wrap", int'(op_count0), 0);
    chk("op_count_wrap_sat", int'(op_count1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
